// File: rtl/jtdd2_subctl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : jtdd2_subctl
// Purpose  : Main-CPU side controller for the DD2 sub-CPU shared-RAM window.
//            Requests/monitors the sub bus, gates shared-RAM selects, fires
//            the sub NMI on release and latches the sub->main IRQ.
// Revision : 1.0 - initial release
// ============================================================================
module jtdd2_subctl #(
   parameter int TOUT_W  = 8,
   parameter int TOUT    = 200,
   parameter int NMI_LEN = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cen4,
   input  logic       ctl_we,
   input  logic [7:0] ctl_din,
   output logic [7:0] status,
   input  logic       main_com_req,
   output logic       com_cs,
   output logic       main_com_err,
   input  logic       mcu_ban,
   output logic       mcu_halt,
   output logic       mcu_nmi_set,
   input  logic       mcu_irqmain,
   output logic       main_irqn
);

   localparam logic [2:0] c_IDLE  = 3'd0;
   localparam logic [2:0] c_REQ   = 3'd1;
   localparam logic [2:0] c_GRANT = 3'd2;
   localparam logic [2:0] c_REL   = 3'd3;
   localparam logic [2:0] c_NMI   = 3'd4;

   localparam int NMI_W = (NMI_LEN < 2) ? 1 : $clog2(NMI_LEN);
   localparam logic [TOUT_W-1:0] c_TOUT_LAST = TOUT_W'(TOUT - 1);
   localparam logic [NMI_W-1:0]  c_NMI_LAST  = NMI_W'(NMI_LEN - 1);

   logic [2:0]        state_q, state_d;
   logic [TOUT_W-1:0] tout_q, tout_d;
   logic [NMI_W-1:0]  nmi_cnt_q, nmi_cnt_d;
   logic              tflag_q, tflag_d;
   logic              nmi_pend_q, nmi_pend_d;
   logic              irq_pend_q, irq_pend_d;
   logic              irq_s_q, irq_prev_q;
   logic              req_prev_q;
   logic              err_q, err_d;
   logic [7:0]        status_q, status_d;

   logic w_irq_rise;
   logic w_req_rise;
   logic w_busy_d;

   assign w_irq_rise = irq_s_q & ~irq_prev_q;
   assign w_req_rise = main_com_req & ~req_prev_q;

   // Halt/NMI decode straight from the state register so an async reset
   // drops them without waiting for a clock.
   assign mcu_halt     = (state_q == c_REQ) || (state_q == c_GRANT);
   assign mcu_nmi_set  = (state_q == c_NMI);
   assign com_cs       = main_com_req && (state_q == c_GRANT);
   assign main_com_err = err_q;
   assign main_irqn    = ~irq_pend_q;
   assign status       = status_q;

   // Next-state logic for the bus handshake FSM and its counters/flags.
   always_comb begin
      state_d    = state_q;
      tout_d     = tout_q;
      nmi_cnt_d  = nmi_cnt_q;
      tflag_d    = tflag_q;
      nmi_pend_d = nmi_pend_q;
      case (state_q)
         c_IDLE: begin
            if (ctl_we && ctl_din[0]) begin
               state_d = c_REQ;
               tout_d  = '0;
               tflag_d = 1'b0;
            end else if (ctl_we && ctl_din[1]) begin
               state_d   = c_NMI;
               nmi_cnt_d = '0;
            end
         end
         c_REQ: begin
            // Grant has priority over a timeout landing on the same edge.
            if (!mcu_ban) begin
               state_d = c_GRANT;
            end else if (cen4) begin
               if (tout_q >= c_TOUT_LAST) begin
                  state_d = c_IDLE;
                  tflag_d = 1'b1;
               end else begin
                  tout_d = tout_q + 1'b1;
               end
            end
         end
         c_GRANT: begin
            if (ctl_we && !ctl_din[0]) begin
               state_d    = c_REL;
               nmi_pend_d = ctl_din[1];
            end
         end
         c_REL: begin
            if (mcu_ban) begin
               if (nmi_pend_q) begin
                  state_d   = c_NMI;
                  nmi_cnt_d = '0;
               end else begin
                  state_d = c_IDLE;
               end
            end
         end
         c_NMI: begin
            if (cen4) begin
               if (nmi_cnt_q >= c_NMI_LAST) begin
                  state_d    = c_IDLE;
                  nmi_pend_d = 1'b0;
               end else begin
                  nmi_cnt_d = nmi_cnt_q + 1'b1;
               end
            end
         end
         default: state_d = c_IDLE;
      endcase
   end

   // IRQ latch, bus-guard error and registered status image of the next state.
   always_comb begin
      irq_pend_d = irq_pend_q;
      if (w_irq_rise) begin
         irq_pend_d = 1'b1;
      end else if (ctl_we && ctl_din[2]) begin
         irq_pend_d = 1'b0;
      end
      err_d    = w_req_rise && (state_q != c_GRANT);
      w_busy_d = (state_d == c_REQ) || (state_d == c_REL) || (state_d == c_NMI);
      status_d = {4'b0000, tflag_d, irq_pend_d, w_busy_d, (state_d == c_GRANT)};
   end

   // State and flag registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= c_IDLE;
         tout_q     <= '0;
         nmi_cnt_q  <= '0;
         tflag_q    <= 1'b0;
         nmi_pend_q <= 1'b0;
         irq_pend_q <= 1'b0;
         irq_s_q    <= 1'b0;
         irq_prev_q <= 1'b0;
         req_prev_q <= 1'b0;
         err_q      <= 1'b0;
         status_q   <= 8'h00;
      end else begin
         state_q    <= state_d;
         tout_q     <= tout_d;
         nmi_cnt_q  <= nmi_cnt_d;
         tflag_q    <= tflag_d;
         nmi_pend_q <= nmi_pend_d;
         irq_pend_q <= irq_pend_d;
         irq_s_q    <= mcu_irqmain;
         irq_prev_q <= irq_s_q;
         req_prev_q <= main_com_req;
         err_q      <= err_d;
         status_q   <= status_d;
      end
   end

endmodule
`default_nettype wire
